// File: rtl/xor_checksum.sv
// Frame checksum: XOR (optionally rotate-then-XOR) over up to FRAME_LEN beats.
// The result is held with a valid/ready handshake until the consumer takes it.
module xor_checksum #(
    parameter int              WIDTH     = 8,
    parameter int              FRAME_LEN = 16,
    parameter logic [WIDTH-1:0] SEED     = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_sum,
    output logic [$clog2(FRAME_LEN):0]   out_count
);

    localparam int CW = $clog2(FRAME_LEN) + 1;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             mode_q;
    logic             eff_mode;
    logic             take;
    logic             frame_end;

    // Rotate-left-by-one of the accumulator; a single bit rotates onto itself.
    generate
        if (WIDTH == 1) begin : g_rot1
            assign rot = acc;
        end else begin : g_rotn
            assign rot = {acc[WIDTH-2:0], acc[WIDTH-1]};
        end
    endgenerate

    // Next accumulator/count; the first beat of a frame supplies the mode.
    always_comb begin
        eff_mode  = (cnt == '0) ? mode : mode_q;
        acc_nxt   = (eff_mode ? rot : acc) ^ in_data;
        cnt_nxt   = cnt + 1'b1;
        take      = in_valid && (state == ACCUM);
        frame_end = take && (in_last || (cnt_nxt == CW'(FRAME_LEN)));
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    // Accumulate beats, capture the result at frame end, release on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= SEED;
            cnt       <= '0;
            mode_q    <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (take) begin
                        acc    <= acc_nxt;
                        cnt    <= cnt_nxt;
                        mode_q <= eff_mode;
                        if (frame_end) begin
                            state     <= HOLD;
                            out_sum   <= acc_nxt;
                            out_count <= cnt_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= ACCUM;
                        acc   <= SEED;
                        cnt   <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_checksum.sv
// Scoreboard bench for xor_checksum (WIDTH=8, FRAME_LEN=4, SEED=0).
// Expected frames are queued at stimulus time and popped on out_valid.
module tb_xor_checksum;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic [2:0] out_count;

    typedef struct {
        logic [7:0] sum;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    xor_checksum #(.WIDTH(8), .FRAME_LEN(4), .SEED(8'h00)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic m,
                                         input logic [7:0] b[4],
                                         input int n);
        logic [7:0] a;
        a = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (m) a = {a[6:0], a[7]};
            a = a ^ b[k];
        end
        return a;
    endfunction

    task automatic beat(input logic [7:0] d, input logic l, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        mode     = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_sum !== 8'h00) begin errors++;
            $display("FAIL reset_out_sum got=%h exp=00", out_sum); end
        checks++; if (out_count !== 3'd0) begin errors++;
            $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    endtask

    task automatic test_mode0();
        bit ok;
        sb.push_back('{8'h0F, 3'd4});
        beat(8'h01, 0, 0);
        beat(8'h02, 0, 0);
        beat(8'h04, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL mode0_early_valid got=%b exp=0", out_valid); end
        beat(8'h08, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++;
            $display("FAIL mode0_latency got=%b exp=1", out_valid); end
        wait_valid(ok);
        e = sb.pop_front();
        checks++; if (!ok) begin errors++;
            $display("FAIL mode0_timeout got=no_valid exp=valid"); end
        checks++; if (out_sum !== e.sum) begin errors++;
            $display("FAIL mode0_sum got=%h exp=%h", out_sum, e.sum); end
        checks++; if (out_count !== e.cnt) begin errors++;
            $display("FAIL mode0_count got=%0d exp=%0d", out_count, e.cnt); end
        release_out();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL mode0_release got=rdy%b/vld%b exp=rdy1/vld0",
                     in_ready, out_valid); end
    endtask

    task automatic test_mode1();
        bit ok;
        sb.push_back('{8'h0A, 3'd4});
        beat(8'h01, 0, 1);
        beat(8'h80, 0, 0);
        beat(8'h00, 0, 1);
        beat(8'h00, 0, 0);
        wait_valid(ok);
        e = sb.pop_front();
        checks++; if (!ok) begin errors++;
            $display("FAIL mode1_timeout got=no_valid exp=valid"); end
        checks++; if (out_sum !== e.sum) begin errors++;
            $display("FAIL mode1_sum got=%h exp=%h", out_sum, e.sum); end
        checks++; if (out_count !== e.cnt) begin errors++;
            $display("FAIL mode1_count got=%0d exp=%0d", out_count, e.cnt); end
        release_out();
    endtask

    task automatic test_early();
        bit ok;
        sb.push_back('{8'hFF, 3'd2});
        beat(8'hAA, 0, 0);
        beat(8'h55, 1, 0);
        wait_valid(ok);
        e = sb.pop_front();
        checks++; if (!ok) begin errors++;
            $display("FAIL early2_timeout got=no_valid exp=valid"); end
        checks++; if (out_sum !== e.sum || out_count !== e.cnt) begin errors++;
            $display("FAIL early2 got=%h/%0d exp=%h/%0d",
                     out_sum, out_count, e.sum, e.cnt); end
        release_out();
        sb.push_back('{8'h3C, 3'd1});
        beat(8'h3C, 1, 1);
        wait_valid(ok);
        e = sb.pop_front();
        checks++; if (!ok) begin errors++;
            $display("FAIL early1_timeout got=no_valid exp=valid"); end
        checks++; if (out_sum !== e.sum || out_count !== e.cnt) begin errors++;
            $display("FAIL early1 got=%h/%0d exp=%h/%0d",
                     out_sum, out_count, e.sum, e.cnt); end
        release_out();
    endtask

    task automatic test_backpressure();
        bit ok;
        sb.push_back('{8'h44, 3'd4});
        beat(8'h11, 0, 0);
        beat(8'h22, 0, 0);
        beat(8'h33, 0, 0);
        beat(8'h44, 0, 0);
        wait_valid(ok);
        e = sb.pop_front();
        checks++; if (!ok) begin errors++;
            $display("FAIL bp_timeout got=no_valid exp=valid"); end
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hE7 + 8'(c);
            in_last  = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_sum !== e.sum || out_count !== e.cnt) begin
                errors++;
                $display("FAIL bp_hold%0d got=v%b r%b %h/%0d exp=v1 r0 %h/%0d",
                         c, out_valid, in_ready, out_sum, out_count,
                         e.sum, e.cnt);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_out();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL bp_release got=rdy%b/vld%b exp=rdy1/vld0",
                     in_ready, out_valid); end
        sb.push_back('{8'h5A, 3'd1});
        beat(8'h5A, 1, 0);
        wait_valid(ok);
        e = sb.pop_front();
        checks++; if (!ok || out_sum !== e.sum || out_count !== e.cnt) begin
            errors++;
            $display("FAIL bp_seed got=%h/%0d exp=%h/%0d",
                     out_sum, out_count, e.sum, e.cnt); end
        release_out();
    endtask

    task automatic test_reset_mid();
        bit ok;
        beat(8'h01, 0, 0);
        beat(8'h02, 0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'h00 || out_count !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_outs got=v%b %h/%0d exp=v0 00/0",
                     out_valid, out_sum, out_count); end
        sb.push_back('{8'hFF, 3'd4});
        beat(8'h11, 0, 0);
        beat(8'h22, 0, 0);
        beat(8'h44, 0, 0);
        beat(8'h88, 0, 0);
        wait_valid(ok);
        e = sb.pop_front();
        checks++; if (!ok || out_sum !== e.sum || out_count !== e.cnt) begin
            errors++;
            $display("FAIL rstmid_frame got=%h/%0d exp=%h/%0d",
                     out_sum, out_count, e.sum, e.cnt); end
        release_out();
    endtask

    task automatic test_gaps();
        bit ok;
        sb.push_back('{8'h0F, 3'd4});
        beat(8'h01, 0, 0);
        idle(2);
        beat(8'h02, 0, 0);
        idle(1);
        beat(8'h04, 0, 0);
        idle(3);
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL gaps_early_valid got=%b exp=0", out_valid); end
        beat(8'h08, 0, 0);
        wait_valid(ok);
        e = sb.pop_front();
        checks++; if (!ok || out_sum !== e.sum || out_count !== e.cnt) begin
            errors++;
            $display("FAIL gaps got=%h/%0d exp=%h/%0d",
                     out_sum, out_count, e.sum, e.cnt); end
        release_out();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] b[4];
        logic m0;
        int n;
        for (int f = 0; f < 8; f++) begin
            n  = $urandom_range(1, 4);
            m0 = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
            sb.push_back('{model(m0, b, n), 3'(n)});
            for (int k = 0; k < n; k++)
                beat(b[k], (k == n - 1) && (n < 4),
                     (k == 0) ? m0 : 1'($urandom_range(0, 1)));
            wait_valid(ok);
            e = sb.pop_front();
            checks++; if (!ok || out_sum !== e.sum || out_count !== e.cnt) begin
                errors++;
                $display("FAIL b2b_%0d got=%h/%0d exp=%h/%0d",
                         f, out_sum, out_count, e.sum, e.cnt); end
            release_out();
        end
        checks++; if (sb.size() != 0) begin errors++;
            $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        idle(1);
        test_reset();
        test_mode0();
        test_mode1();
        test_early();
        test_backpressure();
        test_reset_mid();
        test_gaps();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_checksum.md
XOR_CHECKSUM -- requirements
Module: xor_checksum

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, giving the data and checksum width in bits (legal range 1..64).
REQ-002 SHALL provide parameter FRAME_LEN, default 16, giving the maximum beats per frame (legal range 2..1024).
REQ-003 SHALL provide parameter SEED, default 0, giving the accumulator value loaded at frame start (WIDTH bits).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL define the ports as follows; CW = clog2(FRAME_LEN)+1.
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  synchronous active-high reset
- mode  input  1  0 = plain XOR, 1 = rotate-left-by-1 then XOR
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  block accepts a beat this cycle
- in_data  input  WIDTH  data word
- in_last  input  1  final beat of frame (early termination)
- out_valid  output  1  checksum available
- out_ready  input  1  consumer takes the checksum this cycle
- out_sum  output  WIDTH  frame checksum
- out_count  output  CW  number of beats in the frame

Function
REQ-006 SHALL implement two states, ACCUM and HOLD; the reset state is ACCUM.
REQ-007 SHALL drive in_ready=1 in ACCUM and in_ready=0 in HOLD.
REQ-008 SHALL accept a beat only when in_valid && in_ready; when in_valid=0, no state changes.
REQ-009 SHALL latch mode on the first accepted beat of each frame and use that latched value for the whole frame; mode changes mid-frame are ignored.
REQ-010 SHALL, for mode 0, update acc <= acc ^ in_data on each accepted beat.
REQ-011 SHALL, for mode 1, update acc <= {acc[WIDTH-2:0], acc[WIDTH-1]} ^ in_data on each accepted beat; for WIDTH=1, rotation is identity.
REQ-012 SHALL start each frame with acc = SEED and the beat counter = 0.
REQ-013 SHALL end the frame on an accepted beat when in_last=1 or when that beat is number FRAME_LEN; both conditions together count as one end.
REQ-014 SHALL, on frame end, enter HOLD on the next edge with out_valid=1, out_sum = final acc (including the last beat), and out_count = beats accepted (1..FRAME_LEN); latency is one cycle from the last accepted beat.
REQ-015 SHALL hold out_sum and out_count stable while out_valid=1 and out_ready=0.
REQ-016 SHALL, in HOLD with out_ready=1, return to ACCUM on the next edge with out_valid=0, acc=SEED and counter=0; the next beat can be accepted in that following cycle.
REQ-017 SHALL ignore out_ready when out_valid=0.
REQ-018 SHALL never let the counter wrap; a beat that is both the first beat and has in_last=1 yields out_count=1.
REQ-019 SHALL keep out_sum and out_count at their last values after the handshake; they are meaningful only while out_valid=1.

Reset
REQ-020 SHALL, when rst=1 at a clock edge, set state=ACCUM, in_ready=1 after the edge, out_valid=0, out_sum=0, out_count=0, acc=SEED, counter=0, latched mode=0.
REQ-021 SHALL have rst override all other inputs, including mid-frame and in HOLD; a partial frame is discarded and no checksum is emitted for it.

Verification (WIDTH=8, FRAME_LEN=4, SEED=0)
REQ-022 SHALL verify mode 0: beats 0x01,0x02,0x04,0x08 on back-to-back cycles -> out_valid one cycle after the 4th beat, out_sum=0x0F, out_count=4.
REQ-023 SHALL verify mode 1: beats 0x01,0x80,0x00,0x00 -> out_sum=0x0A, out_count=4; toggling mode after beat 1 does not change the result.
REQ-024 SHALL verify early termination: 0xAA, then 0x55 with in_last=1 -> out_sum=0xFF, out_count=2; in_last on the first beat with 0x3C -> out_sum=0x3C, out_count=1.
REQ-025 SHALL verify backpressure: out_ready=0 for 3 cycles in HOLD -> out_valid, out_sum and out_count stable, in_ready=0, and in_valid beats are not absorbed; out_ready=1 -> in_ready=1 next cycle and the next frame starts from SEED.
REQ-026 SHALL verify reset mid-frame: rst after 2 of 4 beats -> outputs 0; a new frame 0x11,0x22,0x44,0x88 -> out_sum=0xFF, out_count=4.
REQ-027 SHALL verify in_valid gaps: idle cycles between beats -> same result as back-to-back.
